gamma_sched_ctrl: RTL and testbench

//  Sequences a shared-counter delay-memory group: generates the gamma-cycle start (grst), the

---
 rtl/gamma_sched_ctrl.sv | 157 +++++++++++++++
 tb/tb_gamma_sched_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_sched_ctrl.sv
// rtl/gamma_sched_ctrl.sv - gamma-cycle sequencer with shadow/active delay tables
//
// Purpose: drives grst/mem_rst and a mirrored gamma phase count for a shared-counter
// delay-memory group, and owns the per-channel delay table. Delay writes land in a
// shadow table; a commit copies shadow->active on a gamma boundary (or at once when idle).
//
// Ports:
//   aclk, rst_n                 clock, asynchronous active-low reset
//   start, stop                 run control pulses
//   cfg_valid/cfg_ready         shadow-table write handshake (cfg_idx, cfg_delay)
//   cfg_commit                  request shadow->active copy
//   grst, mem_rst               datapath gamma start / unit reset
//   gamma_cnt, gamma_start      phase count and its zero marker while running
//   running                     high while cycling (RUN or DRAIN)
//   commit_done                 one-cycle pulse when the active table changed
//   delay_flat                  active delays, channel i at [i*CW +: CW]
module gamma_sched_ctrl #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int WIDTH             = 128,
    parameter int INIT_CYCLES       = 2,
    localparam int CW = $clog2(GAMMA_CYCLE_WIDTH),
    localparam int IW = $clog2(WIDTH)
) (
    input  logic                aclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IW-1:0]       cfg_idx,
    input  logic [CW-1:0]       cfg_delay,
    input  logic                cfg_commit,
    output logic                grst,
    output logic                mem_rst,
    output logic [CW-1:0]       gamma_cnt,
    output logic                gamma_start,
    output logic                running,
    output logic                commit_done,
    output logic [WIDTH*CW-1:0] delay_flat
);

    localparam int NW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_PHASE = CW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [NW-1:0] INIT_LAST  = NW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN} state_t;

    state_t                   state;
    logic [NW-1:0]            init_cnt;
    logic                     ready_en;
    logic                     commit_pending;
    logic [WIDTH-1:0][CW-1:0] shadow_q;
    logic [WIDTH-1:0][CW-1:0] shadow_d;
    logic [WIDTH-1:0][CW-1:0] active_q;
    logic                     last_phase;
    logic                     copy_fire;
    logic                     write_ok;
    logic                     idx_ok;

    // Out-of-range indices are accepted but dropped; with a power-of-2 table none exist.
    generate
        if (WIDTH == (1 << IW)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = (cfg_idx < IW'(WIDTH));
        end
    endgenerate

    always_comb begin
        last_phase = (gamma_cnt == LAST_PHASE);
        // While cycling, copy only on the last phase so the new table starts at phase 0.
        // When stopped, copy at the first edge that sees the request (pending or live pulse).
        copy_fire  = running ? (commit_pending && last_phase)
                             : (commit_pending || cfg_commit);
        // Writes are blocked only in a cycle where a pending copy is about to happen.
        cfg_ready  = ready_en && !(commit_pending && (!running || last_phase));
        write_ok   = cfg_valid && cfg_ready && idx_ok;
        shadow_d   = shadow_q;
        if (write_ok) begin
            shadow_d[cfg_idx] = cfg_delay;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            init_cnt    <= '0;
            ready_en    <= 1'b0;
            grst        <= 1'b1;
            mem_rst     <= 1'b1;
            gamma_cnt   <= '0;
            gamma_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state    <= S_INIT;
                        init_cnt <= '0;
                    end
                end
                S_INIT: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (init_cnt == INIT_LAST) begin
                        state       <= S_RUN;
                        grst        <= 1'b0;
                        mem_rst     <= 1'b0;
                        gamma_cnt   <= '0;
                        gamma_start <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_RUN, S_DRAIN: begin
                    // G is a power of 2, so the counter wraps G-1 -> 0 on its own.
                    gamma_cnt   <= gamma_cnt + 1'b1;
                    gamma_start <= last_phase;
                    if (state == S_DRAIN && last_phase) begin
                        state       <= S_IDLE;
                        grst        <= 1'b1;
                        mem_rst     <= 1'b1;
                        running     <= 1'b0;
                        gamma_start <= 1'b0;
                    end else if (state == S_RUN && stop) begin
                        state <= S_DRAIN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q       <= '0;
            active_q       <= '0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            commit_done <= copy_fire;
            if (copy_fire) begin
                // shadow_d includes a same-cycle write, so it joins this commit.
                active_q       <= shadow_d;
                commit_pending <= 1'b0;
            end else if (cfg_commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    assign delay_flat = active_q;

endmodule

// File: tb/tb_gamma_sched_ctrl.sv
// tb/tb_gamma_sched_ctrl.sv - self-checking bench for gamma_sched_ctrl
module tb_gamma_sched_ctrl;

    logic         aclk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [6:0]   cfg_idx = '0;
    logic [3:0]   cfg_delay = '0;
    logic         cfg_commit = 1'b0;
    logic         grst;
    logic         mem_rst;
    logic [3:0]   gamma_cnt;
    logic         gamma_start;
    logic         running;
    logic         commit_done;
    logic [511:0] delay_flat;

    int checks = 0;
    int failures = 0;

    gamma_sched_ctrl dut (
        .aclk        (aclk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idx     (cfg_idx),
        .cfg_delay   (cfg_delay),
        .cfg_commit  (cfg_commit),
        .grst        (grst),
        .mem_rst     (mem_rst),
        .gamma_cnt   (gamma_cnt),
        .gamma_start (gamma_start),
        .running     (running),
        .commit_done (commit_done),
        .delay_flat  (delay_flat)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic       st, sp, cv;
        logic [6:0] idx;
        logic [3:0] dly;
        logic       cm;
        logic       e_grst;
        logic [3:0] e_cnt;
        logic       e_run, e_gs, e_done, e_rdy;
        int         ch;
        logic [3:0] e_ch;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, sp, cv, input int idx, dly, input logic cm,
                                input logic g, input int cnt, input logic r, gs, d, rdy,
                                input int ch, ech);
        vec_t v;
        v.st = st; v.sp = sp; v.cv = cv; v.idx = 7'(idx); v.dly = 4'(dly); v.cm = cm;
        v.e_grst = g; v.e_cnt = 4'(cnt); v.e_run = r; v.e_gs = gs; v.e_done = d;
        v.e_rdy = rdy; v.ch = ch; v.e_ch = 4'(ech);
        vecs.push_back(v);
    endfunction

    function automatic logic [3:0] chan(input int i);
        return delay_flat[i*4 +: 4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_cnt(input logic [3:0] target);
        int n = 0;
        while (!(running && gamma_cnt == target) && n < 40) begin
            step();
            n++;
        end
        chk($sformatf("wait_cnt_%0d", target), {31'b0, running && gamma_cnt == target}, 32'd1);
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_grst", grst, 1);
        chk("rst_mem_rst", mem_rst, 1);
        chk("rst_cnt", gamma_cnt, 0);
        chk("rst_gstart", gamma_start, 0);
        chk("rst_running", running, 0);
        chk("rst_done", commit_done, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_table", {31'b0, delay_flat == '0}, 1);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", cfg_ready, 1);

        // Start/run timing plus a mid-cycle commit deferred to the next boundary
        add(1,0,0,0,0,0,   1,0,0,0,0,1, 5,0);    // t1 INIT
        add(0,0,0,0,0,0,   1,0,0,0,0,1, 5,0);    // t2 INIT
        add(0,0,0,0,0,0,   0,0,1,1,0,1, 5,0);    // t3 RUN cnt0
        add(0,0,1,5,7,0,   0,1,1,0,0,1, 5,0);    // write ch5=7 (shadow only)
        add(0,0,1,127,15,0,0,2,1,0,0,1, 127,0);  // write ch127=15
        add(0,0,0,0,0,0,   0,3,1,0,0,1, 5,0);
        add(0,0,0,0,0,1,   0,4,1,0,0,1, 5,0);    // commit sampled at cnt3
        for (int c = 5; c <= 14; c++) add(0,0,0,0,0,0, 0,c,1,0,0,1, 5,0);
        add(0,0,0,0,0,0,   0,15,1,0,0,0, 5,0);   // copy cycle: not ready
        add(0,0,0,0,0,0,   0,0,1,1,1,1, 5,7);    // new table at cnt0
        add(0,0,0,0,0,0,   0,1,1,0,0,1, 127,15);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; stop = vecs[i].sp; cfg_valid = vecs[i].cv;
            cfg_idx = vecs[i].idx; cfg_delay = vecs[i].dly; cfg_commit = vecs[i].cm;
            step();
            start = 0; stop = 0; cfg_valid = 0; cfg_commit = 0;
            chk($sformatf("row%0d_grst", i), grst, vecs[i].e_grst);
            chk($sformatf("row%0d_mem_rst", i), mem_rst, vecs[i].e_grst);
            chk($sformatf("row%0d_cnt", i), gamma_cnt, vecs[i].e_cnt);
            chk($sformatf("row%0d_running", i), running, vecs[i].e_run);
            chk($sformatf("row%0d_gstart", i), gamma_start, vecs[i].e_gs);
            chk($sformatf("row%0d_done", i), commit_done, vecs[i].e_done);
            chk($sformatf("row%0d_ready", i), cfg_ready, vecs[i].e_rdy);
            chk($sformatf("row%0d_ch%0d", i, vecs[i].ch), chan(vecs[i].ch), vecs[i].e_ch);
        end

        // Stop at cnt6: drain to cnt15, start during DRAIN ignored
        wait_cnt(4'd6);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("drain_cnt7", gamma_cnt, 7);
        chk("drain_run7", running, 1);
        for (int c = 8; c <= 15; c++) begin
            start = (c == 9);
            step();
            chk($sformatf("drain_cnt%0d", c), gamma_cnt, c);
            chk($sformatf("drain_run%0d", c), running, 1);
            chk($sformatf("drain_grst%0d", c), grst, 0);
        end
        start = 1'b0;
        step();
        chk("drain_end_grst", grst, 1);
        chk("drain_end_mem_rst", mem_rst, 1);
        chk("drain_end_running", running, 0);
        chk("drain_end_cnt", gamma_cnt, 0);
        chk("drain_end_gstart", gamma_start, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("idle_after_drain%0d", k), running, 0);
        end

        // Idle commit: same-cycle write included, commit_done next cycle
        cfg_valid = 1'b1; cfg_idx = 7'd9; cfg_delay = 4'd3; cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        chk("idle_commit_ch9", chan(9), 3);
        chk("idle_commit_done", commit_done, 1);
        chk("idle_commit_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_delay = 4'd5;
        step();
        cfg_valid = 1'b0;
        chk("idle_done_clear", commit_done, 0);
        chk("idle_write_no_commit", chan(9), 3);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        chk("idle_commit2_done", commit_done, 1);
        chk("idle_commit2_ch9", chan(9), 5);

        // start & stop together in IDLE: stay idle
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("startstop_run%0d", k), running, 0);
            chk($sformatf("startstop_grst%0d", k), grst, 1);
        end
        // stop during INIT: back to IDLE, RUN never entered
        start = 1'b1;
        step();
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("init_stop_run%0d", k), running, 0);
        end

        // Async reset mid-RUN with a commit pending
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cnt(4'd0);
        cfg_valid = 1'b1; cfg_idx = 7'd20; cfg_delay = 4'd11; cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        wait_cnt(4'd9);
        chk("pre_rst_ch9", chan(9), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grst", grst, 1);
        chk("async_mem_rst", mem_rst, 1);
        chk("async_cnt", gamma_cnt, 0);
        chk("async_running", running, 0);
        chk("async_ch9", chan(9), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("no_done_after_rst%0d", k), commit_done, 0);
        end
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        chk("post_rst_commit_done", commit_done, 1);
        chk("post_rst_shadow_ch20", chan(20), 0);
        chk("post_rst_shadow_ch9", chan(9), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
